// File: rtl/hc595_rx_pkg.sv
// Shared widths and frame layout for the 74HC595 link receiver.
// The frame is {seg, sel}, sent MSB first.
package hc595_pkg;

    localparam int SEG_W    = 8;
    localparam int SEL_W    = 6;
    localparam int WORD_W   = SEG_W + SEL_W;
    localparam int BITCNT_W = 4;

    // Field offsets inside the shifted word.
    localparam int SEL_LSB  = 0;
    localparam int SEG_LSB  = SEL_W;

    localparam logic [BITCNT_W-1:0] FULL_BITS = BITCNT_W'(WORD_W);

endpackage

// File: rtl/hc595_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line.
// Outputs the synchronised level and a single-cycle rising-edge pulse.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hc595_rx.sv
// Receiver for the ds/shcp/stcp/oe 74HC595 link: shifts ds on shcp rises,
// latches the 14-bit frame on stcp rises and reports framing errors.
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             ds,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             oe,
    output logic [SEG_W-1:0] seg,
    output logic [SEL_W-1:0] sel,
    output logic             disp_en,
    output logic             word_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    function automatic logic [BITCNT_W-1:0] sat_inc_bits(input logic [BITCNT_W-1:0] v);
        return (&v) ? v : v + BITCNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic ds_s, ds_rise_unused;
    logic shcp_rise, shcp_lvl_unused;
    logic stcp_rise, stcp_lvl_unused;
    logic oe_s, oe_rise_unused;

    logic [WORD_W-1:0]   sreg;
    logic [BITCNT_W-1:0] bit_cnt;

    // ds goes through the same depth as shcp so the bit seen at a shcp
    // rise is the one that was on the wire at the external edge.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds (
        .clk(sys_clk), .rst(sys_rst), .din(ds),
        .level(ds_s), .rise(ds_rise_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shcp (
        .clk(sys_clk), .rst(sys_rst), .din(shcp),
        .level(shcp_lvl_unused), .rise(shcp_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk(sys_clk), .rst(sys_rst), .din(stcp),
        .level(stcp_lvl_unused), .rise(stcp_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
        .clk(sys_clk), .rst(sys_rst), .din(oe),
        .level(oe_s), .rise(oe_rise_unused)
    );

    // Shift / latch stage: a coincident stcp rise latches the pre-shift
    // word and judges it on the pre-shift count, like a real 595.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            seg        <= '0;
            sel        <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            disp_en    <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            disp_en    <= ~oe_s;

            if (stcp_rise) begin
                seg        <= sreg[SEG_LSB +: SEG_W];
                sel        <= sreg[SEL_LSB +: SEL_W];
                word_valid <= 1'b1;
                frame_cnt  <= frame_cnt + CNT_W'(1);
                if (bit_cnt != FULL_BITS) begin
                    frame_err <= 1'b1;
                    err_cnt   <= sat_inc_cnt(err_cnt);
                end
            end

            if (shcp_rise) begin
                sreg    <= {sreg[WORD_W-2:0], ds_s};
                bit_cnt <= stcp_rise ? BITCNT_W'(1) : sat_inc_bits(bit_cnt);
            end else if (stcp_rise) begin
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hc595_rx.sv
// Scoreboard bench for hc595_rx: a bit-level model predicts each latched
// frame when stcp is driven; the monitor compares on every word_valid.
module tb_hc595_rx;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [7:0]       seg;
        logic [5:0]       sel;
        logic             err;
        logic [CNT_W-1:0] fcnt;
        logic [CNT_W-1:0] ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, ds, shcp, stcp, oe;
    logic [7:0]       seg;
    logic [5:0]       sel;
    logic             disp_en, word_valid, frame_err;
    logic [CNT_W-1:0] frame_cnt, err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    logic [13:0]      m_sreg;
    logic [3:0]       m_bitcnt;
    logic [CNT_W-1:0] m_fcnt, m_ecnt;

    always #5 clk = ~clk;

    hc595_rx #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .sys_clk(clk), .sys_rst(rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
        .seg(seg), .sel(sel), .disp_en(disp_en), .word_valid(word_valid),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_sreg   = '0;
        m_bitcnt = '0;
        m_fcnt   = '0;
        m_ecnt   = '0;
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        idle(3);
        shcp = 1'b1;
        m_sreg   = {m_sreg[12:0], b};
        m_bitcnt = (m_bitcnt == 4'hF) ? m_bitcnt : m_bitcnt + 4'd1;
        idle(3);
        shcp = 1'b0;
        idle(3);
    endtask

    task automatic send(input logic [15:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(word[i]);
    endtask

    // Raise stcp (optionally together with shcp carrying bit b) and check
    // the word_valid latency and width.
    task automatic strobe(input logic with_shift, input logic b);
        exp_t e;
        if (with_shift) begin
            ds = b;
            idle(3);
        end
        e.seg = m_sreg[13:6];
        e.sel = m_sreg[5:0];
        e.err = (m_bitcnt != 4'd14);
        m_fcnt = m_fcnt + 1'b1;
        if (e.err && m_ecnt != '1) m_ecnt = m_ecnt + 1'b1;
        e.fcnt = m_fcnt;
        e.ecnt = m_ecnt;
        sb.push_back(e);
        if (with_shift) begin
            m_sreg   = {m_sreg[12:0], b};
            m_bitcnt = 4'd1;
        end else begin
            m_bitcnt = 4'd0;
        end
        stcp = 1'b1;
        if (with_shift) shcp = 1'b1;
        idle(2);
        check("wv_early", word_valid, 0);
        idle(1);
        check("wv_latency", word_valid, 1);
        idle(1);
        check("wv_width", word_valid, 0);
        idle(1);
        stcp = 1'b0;
        shcp = 1'b0;
        idle(4);
    endtask

    always @(negedge clk) begin
        if (!rst && word_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("seg", seg, e.seg);
                check("sel", sel, e.sel);
                check("frame_err", frame_err, e.err);
                check("frame_cnt", frame_cnt, e.fcnt);
                check("err_cnt", err_cnt, e.ecnt);
            end
        end else if (!rst && frame_err) begin
            check("err_without_valid", frame_err, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
        model_reset();
        idle(3);
        check("rst_seg", seg, 0);
        check("rst_sel", sel, 0);
        check("rst_wv", word_valid, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_ecnt", err_cnt, 0);
        check("rst_disp_en", disp_en, 0);
        rst = 1'b0;
        idle(3);

        // Good frame
        send(16'b11000000_000001, 14);
        strobe(1'b0, 1'b0);
        check("t1_seg", seg, 8'hC0);
        check("t1_sel", sel, 6'h01);

        // Short frame, then over-long frame
        send(16'h1555, 13);
        strobe(1'b0, 1'b0);
        send(16'h7FFF, 15);
        strobe(1'b0, 1'b0);
        check("t2_seg", seg, 8'hFF);
        check("t2_sel", sel, 6'h3F);

        // Coincident shcp/stcp rise, then 13 more shifts complete a frame
        send(16'h2469, 13);
        strobe(1'b1, 1'b1);
        send(16'h0F0F, 13);
        strobe(1'b0, 1'b0);

        // Reset mid-frame
        send(16'h007F, 7);
        rst = 1'b1;
        idle(2);
        check("mid_rst_seg", seg, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_fcnt", frame_cnt, 0);
        check("mid_rst_ecnt", err_cnt, 0);
        check("mid_rst_wv", word_valid, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_disp_en", disp_en, 0);
        rst = 1'b0;
        model_reset();
        idle(3);
        send(16'h2AAA, 14);
        strobe(1'b0, 1'b0);
        check("t4_seg", seg, 8'hAA);
        check("t4_sel", sel, 6'h2A);

        // Output enable follows oe inverted and leaves seg/sel alone
        oe = 1'b0;
        for (int i = 0; i < 5 && disp_en !== 1'b1; i++) @(negedge clk);
        check("disp_en_on", disp_en, 1);
        check("oe_seg_hold", seg, 8'hAA);
        oe = 1'b1;
        for (int i = 0; i < 5 && disp_en !== 1'b0; i++) @(negedge clk);
        check("disp_en_off", disp_en, 0);
        check("oe_sel_hold", sel, 6'h2A);

        // Empty frames: err_cnt saturates while frame_cnt wraps
        for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0);
        check("sat_ecnt", err_cnt, 2'd3);
        check("wrap_fcnt", frame_cnt, 2'd2);

        idle(5);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
